// File: rtl/cache_arbiter.sv
// ----------------------------------------------------------------------------
// cache_arbiter: shares one physical-memory port between I-cache and D-cache.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cache_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 256,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  icache_pmem_read,
  input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
  output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
  output logic                  icache_pmem_resp,
  input  logic                  dcache_pmem_read,
  input  logic                  dcache_pmem_write,
  input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
  input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
  output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
  output logic                  dcache_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_last_d;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_i;
  logic w_grant_d;
  logic w_busy;

  assign w_i_req = icache_pmem_read;
  assign w_d_req = dcache_pmem_read | dcache_pmem_write;

  // On a tie, round-robin hands the grant to whoever was not served last.
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (w_i_req && w_d_req) begin
      if ((ROUND_ROBIN != 0) && r_last_d) begin
        w_grant_i = 1'b1;
      end else begin
        w_grant_d = 1'b1;
      end
    end else begin
      w_grant_i = w_i_req;
      w_grant_d = w_d_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state  <= SERVE_D;
            r_last_d <= 1'b1;
            r_addr   <= dcache_pmem_address;
            r_wdata  <= dcache_pmem_wdata;
            // Read+write together is illegal; the writeback takes precedence.
            r_write  <= dcache_pmem_write;
          end else if (w_grant_i) begin
            r_state  <= SERVE_I;
            r_last_d <= 1'b0;
            r_addr   <= icache_pmem_address;
            r_wdata  <= '0;
            r_write  <= 1'b0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_busy       = (r_state != IDLE);
  assign pmem_read    = w_busy & ~r_write;
  assign pmem_write   = w_busy & r_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;

  assign icache_pmem_resp  = (r_state == SERVE_I) & pmem_resp;
  assign dcache_pmem_resp  = (r_state == SERVE_D) & pmem_resp;
  assign icache_pmem_rdata = icache_pmem_resp ? pmem_rdata : '0;
  assign dcache_pmem_rdata = dcache_pmem_resp ? pmem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cache_arbiter: scoreboard bench for cache_arbiter (round-robin and fixed).
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          icache_pmem_read = 1'b0;
  logic [AW-1:0] icache_pmem_address = '0;
  logic          dcache_pmem_read = 1'b0;
  logic          dcache_pmem_write = 1'b0;
  logic [AW-1:0] dcache_pmem_address = '0;
  logic [LW-1:0] dcache_pmem_wdata = '0;
  logic [LW-1:0] mem_rdata = '1;
  logic          mem_resp = 1'b0;
  logic          sel = 1'b1;

  logic [LW-1:0] irdata_rr, drdata_rr, wdata_rr, irdata_fp, drdata_fp, wdata_fp;
  logic          iresp_rr, dresp_rr, rd_rr, wr_rr, iresp_fp, dresp_fp, rd_fp, wr_fp;
  logic [AW-1:0] addr_rr, addr_fp;
  logic          resp_rr, resp_fp;

  assign resp_rr = sel & mem_resp;
  assign resp_fp = ~sel & mem_resp;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .icache_pmem_read(icache_pmem_read), .icache_pmem_address(icache_pmem_address),
    .icache_pmem_rdata(irdata_rr), .icache_pmem_resp(iresp_rr),
    .dcache_pmem_read(dcache_pmem_read), .dcache_pmem_write(dcache_pmem_write),
    .dcache_pmem_address(dcache_pmem_address), .dcache_pmem_wdata(dcache_pmem_wdata),
    .dcache_pmem_rdata(drdata_rr), .dcache_pmem_resp(dresp_rr),
    .pmem_read(rd_rr), .pmem_write(wr_rr), .pmem_address(addr_rr), .pmem_wdata(wdata_rr),
    .pmem_rdata(mem_rdata), .pmem_resp(resp_rr)
  );

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .icache_pmem_read(icache_pmem_read), .icache_pmem_address(icache_pmem_address),
    .icache_pmem_rdata(irdata_fp), .icache_pmem_resp(iresp_fp),
    .dcache_pmem_read(dcache_pmem_read), .dcache_pmem_write(dcache_pmem_write),
    .dcache_pmem_address(dcache_pmem_address), .dcache_pmem_wdata(dcache_pmem_wdata),
    .dcache_pmem_rdata(drdata_fp), .dcache_pmem_resp(dresp_fp),
    .pmem_read(rd_fp), .pmem_write(wr_fp), .pmem_address(addr_fp), .pmem_wdata(wdata_fp),
    .pmem_rdata(mem_rdata), .pmem_resp(resp_fp)
  );

  logic          w_read, w_write, w_iresp, w_dresp;
  logic [AW-1:0] w_addr;
  logic [LW-1:0] w_wdata, w_irdata, w_drdata;
  assign w_read   = sel ? rd_rr     : rd_fp;
  assign w_write  = sel ? wr_rr     : wr_fp;
  assign w_addr   = sel ? addr_rr   : addr_fp;
  assign w_wdata  = sel ? wdata_rr  : wdata_fp;
  assign w_iresp  = sel ? iresp_rr  : iresp_fp;
  assign w_dresp  = sel ? dresp_rr  : dresp_fp;
  assign w_irdata = sel ? irdata_rr : irdata_fp;
  assign w_drdata = sel ? drdata_rr : drdata_fp;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } txn_t;

  txn_t          exp_pmem[$];
  logic [LW-1:0] exp_i[$];
  logic [LW-1:0] exp_d[$];
  int tests = 0;
  int fails = 0;

  function automatic logic [LW-1:0] mem_data(input logic [AW-1:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [LW-1:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got %h, required no event", name, act);
  endtask

  task automatic push_pmem(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
    txn_t t;
    t.wr = wr;
    t.addr = a;
    t.wdata = wd;
    exp_pmem.push_back(t);
  endtask

  // Memory model: accepts a request, checks it against the expected grant
  // order, holds it for mem_lat cycles and returns a one-cycle response.
  int   mem_lat = 5;
  logic busy = 1'b0;
  int   cnt = 0;
  int   cyc = 0;
  int   last_resp_cyc = -100;
  int   last_gap = 0;
  txn_t cur;

  always begin
    @(posedge clk);
    #1;
    cyc++;
    mem_resp  = 1'b0;
    mem_rdata = {8{32'hDEAD_BEEF}};
    if (!rst_n) begin
      busy = 1'b0;
      last_resp_cyc = -100;
    end else if (busy) begin
      check("pmem_hold_read", w_read, !cur.wr);
      check("pmem_hold_write", w_write, cur.wr);
      check("pmem_hold_addr", w_addr, cur.addr);
      if (cnt <= 1) begin
        mem_resp = 1'b1;
        mem_rdata = mem_data(cur.addr);
        busy = 1'b0;
        last_resp_cyc = cyc;
      end else begin
        cnt--;
      end
    end else if (w_read || w_write) begin
      last_gap = cyc - last_resp_cyc;
      check("pmem_bubble", (last_gap >= 2), 1'b1);
      if (exp_pmem.size() == 0) begin
        flag("pmem_unexpected", w_addr);
        cur.wr = w_write;
        cur.addr = w_addr;
        cur.wdata = w_wdata;
      end else begin
        cur = exp_pmem.pop_front();
        check("pmem_read", w_read, !cur.wr);
        check("pmem_write", w_write, cur.wr);
        check("pmem_addr", w_addr, cur.addr);
        if (cur.wr) check("pmem_wdata", w_wdata, cur.wdata);
      end
      busy = 1'b1;
      cnt = mem_lat;
    end
  end

  // Response monitor: pops the per-cache scoreboard on each resp.
  always @(negedge clk) begin
    if (rst_n) begin
      if (w_iresp && w_dresp) flag("both_resp", 1'b1);
      if (w_iresp) begin
        if (exp_i.size() == 0) flag("icache_resp_unexpected", w_irdata);
        else check("icache_rdata", w_irdata, exp_i.pop_front());
      end else if (w_irdata !== '0) begin
        check("icache_rdata_gated", w_irdata, '0);
      end
      if (w_dresp) begin
        if (exp_d.size() == 0) flag("dcache_resp_unexpected", w_drdata);
        else check("dcache_rdata", w_drdata, exp_d.pop_front());
      end else if (w_drdata !== '0) begin
        check("dcache_rdata_gated", w_drdata, '0);
      end
    end
  end

  task automatic icache_req(input logic [AW-1:0] a, input int budget);
    bit seen;
    seen = 1'b0;
    @(posedge clk);
    #1;
    icache_pmem_read = 1'b1;
    icache_pmem_address = a;
    exp_i.push_back(mem_data(a));
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (w_iresp) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) flag("icache_timeout", a);
    icache_pmem_read = 1'b0;
  endtask

  task automatic dcache_req(input logic [AW-1:0] a, input logic rd, input logic wr,
                            input logic [LW-1:0] wd, input int budget);
    bit seen;
    seen = 1'b0;
    @(posedge clk);
    #1;
    dcache_pmem_read = rd;
    dcache_pmem_write = wr;
    dcache_pmem_address = a;
    dcache_pmem_wdata = wd;
    exp_d.push_back(mem_data(a));
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (w_dresp) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) flag("dcache_timeout", a);
    dcache_pmem_read = 1'b0;
    dcache_pmem_write = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] pat_b;
    pat_b = {8{32'hB0B0_2040}};

    // Reset state of every output
    #12;
    check("rst_read", w_read, 1'b0);
    check("rst_write", w_write, 1'b0);
    check("rst_addr", w_addr, '0);
    check("rst_wdata", w_wdata, '0);
    check("rst_iresp", w_iresp, 1'b0);
    check("rst_dresp", w_dresp, 1'b0);
    check("rst_irdata", w_irdata, '0);
    check("rst_drdata", w_drdata, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // I-cache read alone with request latency check
    push_pmem(1'b0, 32'h0000_1000, '0);
    fork
      icache_req(32'h0000_1000, 50);
      begin
        @(posedge clk);
        #2;
        check("lat_read_early", w_read, 1'b0);
        @(posedge clk);
        #2;
        check("lat_read", w_read, 1'b1);
        check("lat_addr", w_addr, 32'h0000_1000);
      end
    join

    // D-cache writeback alone
    push_pmem(1'b1, 32'h0000_2040, pat_b);
    dcache_req(32'h0000_2040, 1'b0, 1'b1, pat_b, 50);

    // First tie after reset: D wins, I follows after one idle cycle
    do_reset();
    push_pmem(1'b0, 32'h0000_0200, '0);
    push_pmem(1'b0, 32'h0000_0100, '0);
    fork
      icache_req(32'h0000_0100, 50);
      dcache_req(32'h0000_0200, 1'b1, 1'b0, '0, 50);
    join
    check("tie1_bubble", last_gap, 2);

    // D alone, then ties alternate: I first each time D was last
    push_pmem(1'b0, 32'h0000_0240, '0);
    dcache_req(32'h0000_0240, 1'b1, 1'b0, '0, 50);
    push_pmem(1'b0, 32'h0000_0110, '0);
    push_pmem(1'b0, 32'h0000_0210, '0);
    fork
      icache_req(32'h0000_0110, 50);
      dcache_req(32'h0000_0210, 1'b1, 1'b0, '0, 50);
    join
    check("tie2_bubble", last_gap, 2);
    push_pmem(1'b0, 32'h0000_0120, '0);
    push_pmem(1'b0, 32'h0000_0220, '0);
    fork
      icache_req(32'h0000_0120, 50);
      dcache_req(32'h0000_0220, 1'b1, 1'b0, '0, 50);
    join

    // Illegal read+write from D: the write is performed
    push_pmem(1'b1, 32'h0000_0700, pat_b ^ {LW{1'b1}});
    dcache_req(32'h0000_0700, 1'b1, 1'b1, pat_b ^ {LW{1'b1}}, 50);

    // Address change after grant must not reach memory
    push_pmem(1'b0, 32'h0000_0300, '0);
    fork
      dcache_req(32'h0000_0300, 1'b1, 1'b0, '0, 50);
      begin
        repeat (3) @(posedge clk);
        #2;
        dcache_pmem_address = 32'h0000_0400;
      end
    join

    // Reset during SERVE_I: request drops at once and no resp follows
    push_pmem(1'b0, 32'h0000_0500, '0);
    @(posedge clk);
    #1;
    icache_pmem_read = 1'b1;
    icache_pmem_address = 32'h0000_0500;
    repeat (3) @(posedge clk);
    #2;
    check("mid_read_before_rst", w_read, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_read", w_read, 1'b0);
    check("mid_rst_iresp", w_iresp, 1'b0);
    icache_pmem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    push_pmem(1'b0, 32'h0000_0600, '0);
    icache_req(32'h0000_0600, 50);

    // Fixed priority: D wins three ties in a row, I waits until D idles
    sel = 1'b0;
    do_reset();
    push_pmem(1'b0, 32'h0000_0800, '0);
    push_pmem(1'b0, 32'h0000_0840, '0);
    push_pmem(1'b0, 32'h0000_0880, '0);
    push_pmem(1'b0, 32'h0000_0180, '0);
    fork
      icache_req(32'h0000_0180, 200);
      begin
        dcache_req(32'h0000_0800, 1'b1, 1'b0, '0, 50);
        dcache_req(32'h0000_0840, 1'b1, 1'b0, '0, 50);
        dcache_req(32'h0000_0880, 1'b1, 1'b0, '0, 50);
      end
    join

    repeat (4) @(negedge clk);
    check("pmem_queue_empty", exp_pmem.size(), 0);
    check("icache_queue_empty", exp_i.size(), 0);
    check("dcache_queue_empty", exp_d.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
